// File: rtl/melody_recorder.sv
// Records held piano keys as {note, octave, duration} segments and plays them back in order.
// Define MELODY_LOOP_EN to make playback wrap to entry 0 until stopped; without it playback ends after the last entry.
module melody_recorder #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 3_125_000,
    parameter int DUR_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_ready,
    input  logic [3:0]             key_note,
    input  logic [3:0]             key_octave,
    input  logic                   rec_start,
    input  logic                   play_start,
    input  logic                   stop,
    output logic [3:0]             note,
    output logic [3:0]             octave,
    output logic                   recording,
    output logic                   playing,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;
    state_t state, state_next;

    logic [3:0]       mem_note [DEPTH];
    logic [3:0]       mem_oct  [DEPTH];
    logic [DUR_W-1:0] mem_dur  [DEPTH];

    logic [TW-1:0]    tick_cnt;
    logic [3:0]       seg_note, seg_oct;
    logic [DUR_W-1:0] seg_dur, dur_eff, play_ticks;
    logic [AW-1:0]    idx, idx_next;
    logic [7:0]       key_val;
    logic             tick, key_changed, last_entry;
    logic             wr_en, restart, play_adv, rec_go;

    assign key_val     = key_ready ? {key_note, key_octave} : 8'h00;
    assign tick        = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
    // A tick landing on the closing edge still belongs to the segment being closed.
    assign dur_eff     = seg_dur + DUR_W'(tick);
    assign key_changed = key_val != {seg_note, seg_oct};
    assign last_entry  = (CW'(idx) + CW'(1)) == count;
    assign rec_go      = restart && (state_next == RECORD);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        restart    = 1'b0;
        play_adv   = 1'b0;
        if (stop) begin
            state_next = IDLE;
            wr_en      = (state == RECORD) && (dur_eff != '0) && !full;
        end else if (play_start) begin
            restart    = 1'b1;
            state_next = (count != '0) ? PLAY : IDLE;
        end else if (rec_start) begin
            restart    = 1'b1;
            state_next = RECORD;
        end else if (state == RECORD) begin
            // Zero-length segments from key glitches are dropped; saturated ones are split.
            wr_en = key_changed ? (dur_eff != '0) : (dur_eff == DUR_MAX);
            if (wr_en && count == CW'(DEPTH - 1)) state_next = IDLE;
        end else if (state == PLAY) begin
            play_adv = tick && ((play_ticks + DUR_W'(1)) == mem_dur[idx]);
            if (play_adv && last_entry && !LOOP) state_next = IDLE;
        end
    end

    always_comb begin
        recording = (state == RECORD);
        playing   = (state == PLAY);
    end

    always_comb begin
        idx_next = idx;
        if (restart)       idx_next = '0;
        else if (play_adv) idx_next = last_entry ? '0 : idx + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || restart || state_next != state || state == IDLE || tick) tick_cnt <= '0;
        else                                                                tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            full     <= 1'b0;
            seg_note <= '0;
            seg_oct  <= '0;
            seg_dur  <= '0;
        end else if (rec_go) begin
            count               <= '0;
            full                <= 1'b0;
            {seg_note, seg_oct} <= key_val;
            seg_dur             <= '0;
        end else begin
            if (wr_en) begin
                count <= count + CW'(1);
                if (count == CW'(DEPTH - 1)) full <= 1'b1;
            end
            if (state == RECORD) begin
                if (key_changed) begin
                    {seg_note, seg_oct} <= key_val;
                    seg_dur             <= '0;
                end else if (dur_eff == DUR_MAX) begin
                    seg_dur <= '0;
                end else begin
                    seg_dur <= dur_eff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_note[count[AW-1:0]] <= seg_note;
            mem_oct[count[AW-1:0]]  <= seg_oct;
            mem_dur[count[AW-1:0]]  <= dur_eff;
        end
    end

    // Output register follows the state being entered: stored entry in PLAY, silence when leaving PLAY, live key otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            play_ticks <= '0;
            note       <= '0;
            octave     <= '0;
        end else begin
            idx <= idx_next;
            if (restart || play_adv)       play_ticks <= '0;
            else if (state == PLAY && tick) play_ticks <= play_ticks + DUR_W'(1);
            if (state_next == PLAY) begin
                note   <= mem_note[idx_next];
                octave <= mem_oct[idx_next];
            end else if (state == PLAY) begin
                {note, octave} <= 8'h00;
            end else begin
                {note, octave} <= key_val;
            end
        end
    end
endmodule

// File: tb/tb_melody_recorder.sv
// Self-checking bench for melody_recorder: main instance (DUR_W=8) plus a DUR_W=2 instance for duration splitting.
// Build with +define+MELODY_LOOP_EN to check looping playback.
module tb_melody_recorder;
    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, key_ready, rec_start, play_start, stop;
    logic [3:0]    key_note, key_octave;
    logic [3:0]    note_m, octave_m, note_s, octave_s;
    logic          recording_m, playing_m, full_m, recording_s, playing_s, full_s;
    logic [CW-1:0] count_m, count_s;
    logic          use_sat;
    logic [7:0]    o_val;
    logic          o_rec, o_play, o_full;
    logic [CW-1:0] o_count;

    melody_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(8)) dut (
        .clk(clk), .rst(rst), .key_ready(key_ready), .key_note(key_note), .key_octave(key_octave),
        .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .note(note_m), .octave(octave_m), .recording(recording_m), .playing(playing_m),
        .full(full_m), .count(count_m)
    );

    melody_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .key_ready(key_ready), .key_note(key_note), .key_octave(key_octave),
        .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .note(note_s), .octave(octave_s), .recording(recording_s), .playing(playing_s),
        .full(full_s), .count(count_s)
    );

    always #5 clk = ~clk;

    assign o_val   = use_sat ? {note_s, octave_s} : {note_m, octave_m};
    assign o_rec   = use_sat ? recording_s : recording_m;
    assign o_play  = use_sat ? playing_s : playing_m;
    assign o_full  = use_sat ? full_s : full_m;
    assign o_count = use_sat ? count_s : count_m;

    typedef struct {
        logic [7:0] val;
        int         dur;
    } seg_t;

    typedef struct {
        logic       rs, ps, sp;
        logic [7:0] key;
        int         reps;
        logic [7:0] exp_val;
        logic       exp_rec, exp_play, exp_full;
        int         exp_count;
    } vec_t;

    seg_t       exp_q[$];
    logic [7:0] trace[$];
    bit         exp_full;
    vec_t       vecs[8];
    int         checks = 0;
    int         errors = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // A zero key value means no key held; the note/octave lines then carry junk that must be ignored.
    task automatic apply_stimulus(input logic rs, input logic ps, input logic sp, input logic [7:0] key);
        rec_start  = rs;
        play_start = ps;
        stop       = sp;
        key_ready  = (key != 8'h00);
        if (key != 8'h00) begin
            {key_note, key_octave} = key;
        end else begin
            key_note   = 4'($urandom);
            key_octave = 4'($urandom);
        end
    endtask

    function automatic logic [7:0] random_key();
        if ($urandom_range(3, 0) == 0) return 8'h00;
        return {4'($urandom_range(12, 1)), 4'($urandom_range(8, 0))};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b1, 1'($urandom), 1'b0, random_key());
        cycle();
        cycle();
        check_output("rst_note", int'(o_val), 0);
        check_output("rst_recording", int'(o_rec), 0);
        check_output("rst_playing", int'(o_play), 0);
        check_output("rst_full", int'(o_full), 0);
        check_output("rst_count", int'(o_count), 0);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Reference: split the per-cycle key trace into runs, credit the tick at edge k+1 to cycle k,
    // drop tickless runs, split runs longer than the duration limit, keep the first DEPTH entries.
    task automatic build_model(input int maxd);
        int         k;
        int         ticks;
        logic [7:0] v;
        exp_q.delete();
        k = 0;
        while (k < trace.size()) begin
            v     = trace[k];
            ticks = 0;
            while (k < trace.size() && trace[k] == v) begin
                if ((k + 1) % TICK_DIV == 0) ticks++;
                k++;
            end
            while (ticks >= maxd) begin
                exp_q.push_back('{v, maxd});
                ticks -= maxd;
            end
            if (ticks > 0) exp_q.push_back('{v, ticks});
        end
        exp_full = (exp_q.size() >= DEPTH);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    endtask

    function automatic logic [7:0] entry_at(input int t);
        int rem = t;
        foreach (exp_q[i]) begin
            if (rem < exp_q[i].dur * TICK_DIV) return exp_q[i].val;
            rem -= exp_q[i].dur * TICK_DIV;
        end
        return 8'h00;
    endfunction

    task automatic record_trace();
        int         s;
        logic [7:0] key;
        s = trace.size();
        for (int k = 0; k <= s; k++) begin
            key = (k < s) ? trace[k] : 8'h00;
            apply_stimulus(k == 0, 1'b0, k == s, key);
            cycle();
            check_output("passthru", int'(o_val), int'(key));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        check_output("rec_count", int'(o_count), exp_q.size());
        check_output("rec_full", int'(o_full), int'(exp_full));
        check_output("rec_recording", int'(o_rec), 0);
    endtask

    task automatic check_playback();
        int         total;
        logic [7:0] expv;
        bit         exp_play;
        total = 0;
        foreach (exp_q[i]) total += exp_q[i].dur * TICK_DIV;
        for (int j = 0; j < total + 6; j++) begin
            apply_stimulus(1'b0, j == 0, 1'b0, (j < total) ? random_key() : 8'h00);
            cycle();
            exp_play = (total > 0) && (j < total || LOOP);
            expv     = exp_play ? entry_at(j % total) : 8'h00;
            check_output("play_note", int'(o_val), int'(expv));
            check_output("playing", int'(o_play), int'(exp_play));
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        check_output("stop_note", int'(o_val), 0);
        check_output("stop_playing", int'(o_play), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_run(input logic [7:0] v, input int len);
        repeat (len) trace.push_back(v);
    endtask

    initial begin
        use_sat = 1'b0;
        rst     = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        do_reset();

        // Rows: rs, ps, sp, key, reps, expected {note,octave}, recording, playing, full, count.
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h14, 1,  8'h14, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1,  8'h00, 1'b0, 1'b0, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h14, 12, 8'h14, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8,  8'h00, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1,  8'h00, 1'b0, 1'b0, 1'b0, 2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h73, 1,  8'h73, 1'b0, 1'b0, 1'b0, 2};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h25, 1,  8'h25, 1'b0, 1'b0, 1'b0, 2};
        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].reps; c++) begin
                apply_stimulus(c == 0 ? vecs[i].rs : 1'b0, c == 0 ? vecs[i].ps : 1'b0,
                               c == 0 ? vecs[i].sp : 1'b0, vecs[i].key);
                cycle();
            end
            check_output($sformatf("v%0d_note", i), int'(o_val), int'(vecs[i].exp_val));
            check_output($sformatf("v%0d_recording", i), int'(o_rec), int'(vecs[i].exp_rec));
            check_output($sformatf("v%0d_playing", i), int'(o_play), int'(vecs[i].exp_play));
            check_output($sformatf("v%0d_full", i), int'(o_full), int'(vecs[i].exp_full));
            check_output($sformatf("v%0d_count", i), int'(o_count), vecs[i].exp_count);
        end

        // Stored melody from the table: C4 for 3 ticks, rest for 2 ticks.
        exp_q.delete();
        exp_q.push_back('{8'h14, 3});
        exp_q.push_back('{8'h00, 2});
        check_playback();

        // All three commands together during playback, then reset mid-playback.
        apply_stimulus(1'b0, 1'b1, 1'b0, random_key());
        cycle();
        check_output("p36_playing", int'(o_play), 1);
        check_output("p36_note", int'(o_val), 8'h14);
        repeat (4) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, random_key());
            cycle();
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, random_key());
        cycle();
        check_output("cmd3_note", int'(o_val), 0);
        check_output("cmd3_playing", int'(o_play), 0);
        check_output("cmd3_recording", int'(o_rec), 0);
        check_output("cmd3_count", int'(o_count), 2);
        apply_stimulus(1'b0, 1'b1, 1'b0, random_key());
        cycle();
        repeat (2) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, random_key());
            cycle();
        end
        do_reset();

        // Glitch 1 -> 2 -> 1: the one-cycle note 2 must not be stored.
        trace.delete();
        push_run(8'h14, 8);
        push_run(8'h24, 1);
        push_run(8'h14, 7);
        build_model(255);
        record_trace();
        check_output("glitch_count", int'(o_count), 2);
        check_playback();

        // Five keys of four ticks each fill a four-entry store.
        do_reset();
        trace.delete();
        for (int n = 1; n <= 5; n++) push_run({4'(n), 4'd4}, 16);
        build_model(255);
        record_trace();
        check_output("full_flag", int'(o_full), 1);
        check_output("full_count", int'(o_count), 4);
        check_playback();

        // Seven ticks on a 2-bit duration split into 3 + 3 + 1.
        use_sat = 1'b1;
        do_reset();
        trace.delete();
        push_run(8'h35, 28);
        build_model(3);
        record_trace();
        check_output("sat_count", int'(o_count), 3);
        check_playback();
        use_sat = 1'b0;

        for (int it = 0; it < 8; it++) begin
            do_reset();
            trace.delete();
            repeat ($urandom_range(6, 1)) push_run(random_key(), $urandom_range(14, 1));
            build_model(255);
            record_trace();
            check_playback();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
